// File: rtl/mem_responder.sv
// mem_responder: word-addressed RAM slave for the CPU bus.
// Captures a request in IDLE, waits WAIT_STATES cycles, performs the access,
// then pulses ack for one cycle.
// Optional feature macro: MEM_RESP_ERR_EN. When defined, out-of-range
// addresses raise err during the response, reads return 0 and writes are
// dropped. When undefined, addresses wrap modulo DEPTH and err stays 0.
module mem_responder #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 16,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              ack,
   output logic              busy,
   output logic              err
);

   localparam int          AW = $clog2(DEPTH);
   localparam logic [3:0]  WS = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACCESS,
      S_RESP
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W-1:0]   r_rdata;
   logic [3:0]          r_cnt;
   logic [DATA_W-1:0]   r_mem [DEPTH];

   logic [AW-1:0]       w_idx;
   logic                w_oor;
   logic                w_capture;
   logic                w_do_write;
   logic                w_do_read;

   assign w_idx = r_addr[AW-1:0];

`ifdef MEM_RESP_ERR_EN
   // Anything at or above DEPTH is flagged; extra top bit keeps DEPTH == 2^ADDR_W legal.
   assign w_oor = ({1'b0, r_addr} >= (ADDR_W+1)'(DEPTH));
`else
   // Addresses wrap: only the low index bits select a word.
   logic w_unused_hi;
   assign w_unused_hi = ^r_addr;
   assign w_oor       = 1'b0;
`endif

   assign w_capture  = (r_state == S_IDLE) && req;
   assign w_do_write = (r_state == S_ACCESS) &&  r_we && !w_oor;
   assign w_do_read  = (r_state == S_ACCESS) && !r_we;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state decode; the wait counter reaching 1 ends the wait phase.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (req) w_next = (WS != 4'd0) ? S_WAIT : S_ACCESS;
         S_WAIT:   if (r_cnt <= 4'd1) w_next = S_ACCESS;
         S_ACCESS: w_next = S_RESP;
         S_RESP:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Request capture and wait countdown; bus inputs are ignored outside IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_cnt   <= 4'd0;
      end else if (w_capture) begin
         r_we    <= we;
         r_addr  <= addr;
         r_wdata <= wdata;
         r_cnt   <= WS;
      end else if (r_state == S_WAIT) begin
         r_cnt   <= r_cnt - 4'd1;
      end
   end

   // Read data register; holds across writes and idle cycles.
   always_ff @(posedge clk) begin
      if (rst)            r_rdata <= '0;
      else if (w_do_read) r_rdata <= w_oor ? '0 : r_mem[w_idx];
   end

   // RAM write port; reset on the access edge suppresses the write.
   always_ff @(posedge clk) begin
      if (!rst && w_do_write) r_mem[w_idx] <= r_wdata;
   end

   assign rdata = r_rdata;
   assign ack   = (r_state == S_RESP);
   assign busy  = (r_state != S_IDLE);
   assign err   = ack && w_oor;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (2 and 0 wait states), a table of
// bus transactions with constant expected results fed through a scoreboard,
// and hand sequences for input changes during wait, reset abort, idle
// quiescence and back-to-back throughput.
module tb_mem_responder;

   localparam int WS0 = 2;
   localparam int WS1 = 0;

   logic        clk = 1'b0;
   logic        rst;
   logic        req   [2];
   logic        we    [2];
   logic [15:0] addr  [2];
   logic [15:0] wdata [2];
   logic [15:0] rdata [2];
   logic        ack   [2];
   logic        busy  [2];
   logic        err   [2];

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   mem_responder #(.WAIT_STATES(WS0)) u_dut0 (
      .clk(clk), .rst(rst), .req(req[0]), .we(we[0]), .addr(addr[0]),
      .wdata(wdata[0]), .rdata(rdata[0]), .ack(ack[0]), .busy(busy[0]), .err(err[0]));

   mem_responder #(.WAIT_STATES(WS1)) u_dut1 (
      .clk(clk), .rst(rst), .req(req[1]), .we(we[1]), .addr(addr[1]),
      .wdata(wdata[1]), .rdata(rdata[1]), .ack(ack[1]), .busy(busy[1]), .err(err[1]));

   typedef struct {
      logic [15:0] rdata;
      logic        err;
   } exp_t;

   typedef struct {
      logic        w;
      logic [15:0] a;
      logic [15:0] d;
      logic [15:0] er;
      logic        ee;
   } vec_t;

   exp_t q0[$];
   exp_t q1[$];
   int   ack1_t[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic push(input int k, input logic [15:0] r, input logic e);
      exp_t x;
      x.rdata = r;
      x.err   = e;
      if (k == 0) q0.push_back(x);
      else        q1.push_back(x);
   endtask

   // Scoreboard: every ack pops one expected response.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (ack[k] === 1'b1) begin
            exp_t x;
            if (k == 1) ack1_t.push_back(cyc);
            if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
               n_chk++;
               $display("FAIL unexpected_ack dut%0d at cycle %0d: got ack=1 expected ack=0", k, cyc);
            end else begin
               x = (k == 0) ? q0.pop_front() : q1.pop_front();
               check($sformatf("rdata dut%0d", k), 32'(rdata[k]), 32'(x.rdata));
               check($sformatf("err dut%0d", k), 32'(err[k]), 32'(x.err));
            end
         end
      end
   end

   task automatic do_txn(input int k, input logic w, input logic [15:0] a, input logic [15:0] d,
                         input logic [15:0] er, input logic ee, input bit perturb, input string nm);
      int  n;
      bit  got;
      @(negedge clk);
      push(k, er, ee);
      req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
      @(posedge clk);
      #1;
      req[k] = 1'b0;
      if (perturb) begin
         addr[k]  = 16'hFFFF;
         wdata[k] = 16'hFFFF;
      end
      n = 0; got = 0;
      while (!got && n < 40) begin
         @(negedge clk);
         n++;
         if (ack[k] === 1'b1) got = 1;
      end
      check({nm, " latency"}, 32'(n), 32'(((k == 0) ? WS0 : WS1) + 2));
   endtask

   vec_t tbl [11];

   initial begin
      tbl[0]  = '{1'b1, 16'h0000, 16'hA5A5, 16'h0000, 1'b0};
      tbl[1]  = '{1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0};
      tbl[2]  = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
      tbl[3]  = '{1'b1, 16'h0007, 16'h5555, 16'hBEEF, 1'b0};
      tbl[4]  = '{1'b1, 16'h0030, 16'h0F0F, 16'hBEEF, 1'b0};
      tbl[5]  = '{1'b1, 16'h00FF, 16'h1357, 16'hBEEF, 1'b0};
      tbl[6]  = '{1'b0, 16'h00FF, 16'h0000, 16'h1357, 1'b0};
`ifdef MEM_RESP_ERR_EN
      tbl[7]  = '{1'b0, 16'h0100, 16'h0000, 16'h0000, 1'b1};
      tbl[8]  = '{1'b1, 16'h0130, 16'h7777, 16'h0000, 1'b1};
      tbl[9]  = '{1'b0, 16'h0030, 16'h0000, 16'h0F0F, 1'b0};
`else
      tbl[7]  = '{1'b0, 16'h0100, 16'h0000, 16'hA5A5, 1'b0};
      tbl[8]  = '{1'b1, 16'h0130, 16'h7777, 16'hA5A5, 1'b0};
      tbl[9]  = '{1'b0, 16'h0030, 16'h0000, 16'h7777, 1'b0};
`endif
      tbl[10] = '{1'b0, 16'h0000, 16'h0000, 16'hA5A5, 1'b0};

      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 2; k++)
         check($sformatf("reset dut%0d", k), {12'd0, ack[k], busy[k], err[k], rdata[k]}, 32'd0);

      // Table-driven transactions on the 2-wait-state instance.
      for (int i = 0; i < 11; i++)
         do_txn(0, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].er, tbl[i].ee, 1'b0, $sformatf("vec%0d", i));

      // Inputs changed during WAIT must not affect the captured write.
      do_txn(0, 1'b1, 16'h0005, 16'h1234, 16'hA5A5, 1'b0, 1'b1, "perturb_wr");
      do_txn(0, 1'b0, 16'h0005, 16'h0000, 16'h1234, 1'b0, 1'b0, "rd5");
`ifdef MEM_RESP_ERR_EN
      do_txn(0, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0, "rdFFFF");
`else
      do_txn(0, 1'b0, 16'hFFFF, 16'h0000, 16'h1357, 1'b0, 1'b0, "rdFFFF");
`endif

      // Reset during WAIT aborts the write and produces no ack.
      @(negedge clk);
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h0007; wdata[0] = 16'hAAAA;
      @(posedge clk);
      #1 req[0] = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_abort outputs", {12'd0, ack[0], busy[0], err[0], rdata[0]}, 32'd0);
      repeat (8) @(negedge clk);
      do_txn(0, 1'b0, 16'h0007, 16'h0000, 16'h5555, 1'b0, 1'b0, "rd7_after_reset");

      // Idle with req low: nothing moves.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check($sformatf("idle%0d", i), {13'd0, ack[0], busy[0], err[0], rdata[0]}, {16'd0, 16'h5555});
      end

      // Zero-wait instance: preload, then back-to-back reads with req held high.
      do_txn(1, 1'b1, 16'h0000, 16'h1111, 16'h0000, 1'b0, 1'b0, "ws0_w0");
      do_txn(1, 1'b1, 16'h0001, 16'h2222, 16'h0000, 1'b0, 1'b0, "ws0_w1");
      do_txn(1, 1'b1, 16'h0002, 16'h3333, 16'h0000, 1'b0, 1'b0, "ws0_w2");
      do_txn(1, 1'b1, 16'h0003, 16'h4444, 16'h0000, 1'b0, 1'b0, "ws0_w3");
      @(negedge clk);
      ack1_t.delete();
      push(1, 16'h1111, 1'b0);
      push(1, 16'h2222, 1'b0);
      push(1, 16'h3333, 1'b0);
      push(1, 16'h4444, 1'b0);
      @(negedge clk);
      req[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h0000;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1 addr[1] = 16'(i + 1);
         repeat (2) @(posedge clk);
      end
      #1 req[1] = 1'b0;
      repeat (3) @(negedge clk);
      check("bb ack count", 32'(ack1_t.size()), 32'd4);
      for (int i = 1; i < ack1_t.size(); i++)
         check($sformatf("bb gap%0d", i), 32'(ack1_t[i] - ack1_t[i-1]), 32'd3);

      repeat (5) @(negedge clk);
      check("sb0 drained", 32'(q0.size()), 32'd0);
      check("sb1 drained", 32'(q1.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   // Hard stop in case something wedges.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
